// File: rtl/cla4_serial_sub.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one 4-bit lookahead chunk per clock.
// Optional build macro SUB_SAT_EN clamps an underflowed result to zero.
module cla4_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow;
    logic [KW-1:0]    k;

    logic [3:0] ca;
    logic [3:0] cb;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] nib;

    assign in_ready = (state == IDLE);

    // Borrow lookahead: generate when a=0,b=1; propagate when a==b.
    always_comb begin
        ca   = a_q[4*int'(k) +: 4];
        cb   = b_q[4*int'(k) +: 4];
        g    = ~ca & cb;
        p    = ~(ca ^ cb);
        c[0] = borrow;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib  = ca ^ cb ^ c[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            borrow    <= 1'b0;
            k         <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        k      <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff[4*int'(k) +: 4] <= nib;
                    borrow <= c[4];
                    k      <= k + 1'b1;
                    if (k == KW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bout      <= c[4];
`ifdef SUB_SAT_EN
                        if (c[4]) diff <= '0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla4_serial_sub.sv
// Scoreboard bench for cla4_serial_sub at WIDTH=16.
module tb_cla4_serial_sub;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int accept_cyc = 0;
    res_t sb[$];

    cla4_serial_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [15:0] av, bv, input logic bi);
        logic [16:0] r;
        res_t e;
        r = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
        e.d = r[15:0];
        e.bo = r[16];
`ifdef SUB_SAT_EN
        if (e.bo) e.d = '0;
`endif
        return e;
    endfunction

    // Issue one op, wait up to a bounded time, then check and retire it.
    task automatic issue(input logic [15:0] av, bv, input logic bi);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready got=%b want=1", in_ready);
        end
        sb.push_back(model(av, bv, bi));
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask

    task automatic wait_result(input string name);
        int cnt;
        res_t e;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        tests++;
        if (cnt !== 4) begin
            fails++;
            $display("FAIL %s_latency got=%0d want=4", name, cnt);
        end
        e = sb.pop_front();
        tests++;
        if (diff !== e.d || bout !== e.bo) begin
            fails++;
            $display("FAIL %s got=%h/%b want=%h/%b", name, diff, bout, e.d, e.bo);
        end
    endtask

    task automatic retire(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_retire ov=%b ir=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic run_op(input logic [15:0] av, bv, input logic bi, input string name);
        issue(av, bv, bi);
        wait_result(name);
        retire(name);
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            tests++;
            if (diff !== 16'h0 || bout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_state d=%h bo=%b ov=%b ir=%b want 0/0/0/1",
                         diff, bout, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle_ov got=%0d want=0", bad);
        end
    endtask

    task automatic test_basic;
        int first;
        run_op(16'h1234, 16'h0234, 1'b0, "basic");
        first = accept_cyc;
        issue(16'h0000, 16'h0000, 1'b1);
        tests++;
        if (accept_cyc - first !== 6) begin
            fails++;
            $display("FAIL issue_interval got=%0d want=6", accept_cyc - first);
        end
        wait_result("zero_bin");
        retire("zero_bin");
    endtask

    task automatic test_boundaries;
        run_op(16'h0000, 16'h0001, 1'b0, "underflow");
        run_op(16'h8000, 16'h7FFF, 1'b1, "cross_chunk_a");
        run_op(16'h0100, 16'h0001, 1'b0, "cross_chunk_b");
        run_op(16'hFFFF, 16'h0000, 1'b1, "max_minus_bin");
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_backpressure;
        res_t e;
        logic [15:0] d0;
        logic        b0;
        int bad;
        out_ready = 1'b0;
        issue(16'hA5A5, 16'h5A5A, 1'b0);
        wait_result("bp_first");
        e = model(16'hA5A5, 16'h5A5A, 1'b0);
        d0 = diff; b0 = bout;
        bad = 0;
        repeat (5) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            if (diff !== e.d || bout !== e.bo || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold bad=%0d want=0 d=%h/%h", bad, diff, d0);
        end
        in_valid = 1'b0;
        retire("bp");
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_single ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        run_op(16'h3C3C, 16'h4000, 1'b1, "bp_next");
    endtask

    task automatic test_mid_reset;
        int bad;
        a = 16'h7777; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 16'h0) begin
            fails++;
            $display("FAIL midrst ov=%b ir=%b d=%h want 0/1/0000", out_valid, in_ready, diff);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midrst_ov got=%0d want=0", bad);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla4_serial_sub.md
# cla4_serial_sub

Multi-cycle unsigned subtractor that computes `diff = a - b - bin` over a WIDTH-bit operand, one 4-bit chunk per clock. Each chunk uses a single 4-bit borrow-lookahead slice. It is the subtract-direction companion to the 4-bit carry-lookahead adder slice in the functional-unit library. It trades latency for area and sits behind a valid/ready handshake on both sides so it can hang off the same operand bus as the adders.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8. N = WIDTH/4 chunks.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands on a/b/bin are valid.
- in_ready  out  1  block can accept operands; combinational from state (IDLE only).
- a  in  WIDTH  minuend, unsigned.
- b  in  WIDTH  subtrahend, unsigned.
- bin  in  1  borrow in.
- out_valid  out  1  diff/bout hold a completed result.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  registered difference.
- bout  out  1  registered borrow out; 1 means the true result a - b - bin < 0.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with:
  - diff = 0, bout = 0, out_valid = 0, chunk counter = 0.
  - in_ready = 1.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - capture a, b into internal registers and bin into the borrow register;
  - clear the counter k to 0; go to RUN.
- RUN: in_ready = 0, out_valid = 0. Each cycle, operate on chunk k (bits 4k+3..4k):
  - per bit: Gb = ~a & b, Pb = ~(a ^ b);
  - nibble borrows via lookahead from the borrow register;
  - diff nibble = a ^ b ^ borrow_chain;
  - write the nibble into diff[4k+3:4k]; update the borrow register with the chunk's group borrow; k++.
- After chunk N-1 is written, go to DONE. At that point bout = final borrow.
- DONE: out_valid = 1 and in_ready = 0. diff/bout are held stable while out_ready = 0. On out_valid & out_ready, go to IDLE. No same-cycle re-accept; IDLE is always entered for ≥ 1 cycle.
- Arithmetic: modulo 2^WIDTH.
  - Example: a=0, b=0, bin=1 → diff = all-ones, bout = 1.
  - bout is the borrow out of the MSB chunk.
- Inputs a/b/bin/in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- diff bits not yet written in RUN hold their previous values. They are don't-care until out_valid.
- Reset asserted in any state aborts the operation with the reset values above. No result is emitted.

## Timing
- Accepting edge E0 (in_valid & in_ready sampled high).
- Chunks 0..N-1 are written on edges E0+1 .. E0+N.
- out_valid is high from E0+N until the edge where out_ready is sampled high (edge Eh).
- in_ready returns high in the cycle following Eh.
- Minimum issue interval: N+2 cycles (WIDTH=16 → 6).
- Critical path: one 4-bit lookahead slice plus the borrow register. It is independent of WIDTH.

## Configuration
- SUB_SAT_EN
  - Defined: when the final borrow is 1, diff is forced to 0 on the transition to DONE (unsigned saturating subtract). bout still reports 1.
  - Undefined: diff is the modulo-2^WIDTH result.
  - Latency and handshake are identical in both builds.

## Test plan
- Reset: hold rst_n=0 with random inputs → diff=0, bout=0, out_valid=0, in_ready=1. Deassert → no out_valid without an accepted input.
- Basic (WIDTH=16): a=0x1234, b=0x0234, bin=0 → out_valid exactly 4 edges after accept, diff=0x1000, bout=0. Next accept is possible no earlier than 6 cycles after the first.
- Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. With SUB_SAT_EN: diff=0x0000, bout=1.
- Cross-chunk borrow: a=0x8000, b=0x7FFF, bin=1 → diff=0x0000, bout=0. a=0x0100, b=0x0001, bin=0 → diff=0x00FF, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b → diff and bout stable, in_ready=0. Then out_ready=1 → one handshake, in_ready=1 the next cycle, and the later result is correct for the new operands.
- Mid-operation reset: pulse rst_n low during RUN (k=2) → immediate IDLE, out_valid never asserted for that operation. The following operation a=0xFFFF, b=0xFFFF, bin=0 → diff=0x0000, bout=0.
